// File: rtl/mod107_digit_serializer_if.sv
// Bus bundle for the mod-107 digit serializer: an operand load channel and a
// digit channel feeding the X_k LUT stage, plus a busy flag.
interface mod107_digit_serializer_if #(
   parameter int W = 300,
   parameter int D = 6
);
   logic         ld_valid;
   logic         ld_ready;
   logic [W-1:0] ld_data;
   logic         dg_valid;
   logic         dg_ready;
   logic [D-1:0] dg_data;
   logic [5:0]   dg_idx;
   logic         dg_last;
   logic         busy;

   // Environment side: offers operands and consumes digits.
   modport master (
      output ld_valid, ld_data, dg_ready,
      input  ld_ready, dg_valid, dg_data, dg_idx, dg_last, busy
   );

   // Serializer side.
   modport slave (
      input  ld_valid, ld_data, dg_ready,
      output ld_ready, dg_valid, dg_data, dg_idx, dg_last, busy
   );
endinterface

// File: rtl/mod107_digit_serializer.sv
// Splits a W-bit operand into N = W/D digits and issues them MSB-first, one per
// accepted handshake, tagged with the digit index that selects the X_k LUT.
module mod107_digit_serializer #(
   parameter int W = 300,
   parameter int D = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mod107_digit_serializer_if.slave     bus
);
   localparam int N = W / D;
   localparam logic [5:0] IDX_TOP = 6'(N - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t       state_reg;
   logic [W-1:0] shift_reg;
   logic [5:0]   idx_reg;
   logic         last_reg;

   // Load / shift state machine; dg_last is kept as its own register so it is
   // ready on the same cycle the index reaches zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         idx_reg   <= '0;
         last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.ld_valid) begin
                  shift_reg <= bus.ld_data;
                  idx_reg   <= IDX_TOP;
                  last_reg  <= (N == 1);
                  state_reg <= SEND;
               end
            end
            SEND: begin
               if (bus.dg_ready) begin
                  if (idx_reg == 6'd0) begin
                     last_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     shift_reg <= shift_reg << D;
                     idx_reg   <= idx_reg - 6'd1;
                     last_reg  <= (idx_reg == 6'd1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Outputs come only from registers, so no input reaches an output in the same cycle.
   assign bus.ld_ready = (state_reg == IDLE);
   assign bus.dg_valid = (state_reg == SEND);
   assign bus.busy     = (state_reg == SEND);
   assign bus.dg_data  = shift_reg[W-1 -: D];
   assign bus.dg_idx   = idx_reg;
   assign bus.dg_last  = last_reg;
endmodule

// File: tb/tb_mod107_digit_serializer.sv
// Scoreboard bench for the mod-107 digit serializer: a reference model queues
// the expected digits of every loaded operand, and a negedge monitor compares
// what the serializer presents, reassembles each operand and its residue.
module tb_mod107_digit_serializer;
   localparam int W = 300;
   localparam int D = 6;
   localparam int N = W / D;

   typedef struct {
      logic [5:0]   idx;
      logic [D-1:0] data;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mod107_digit_serializer_if #(.W(W), .D(D)) bus ();

   mod107_digit_serializer #(.W(W), .D(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t         exp_q[$];
   logic [W-1:0] op_q[$];
   logic [W-1:0] acc;
   int           res;
   int           xk[64];
   exp_t         e;
   logic [W-1:0] op;
   logic         sending;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v = '0;
      for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   // Reference residue by bitwise Horner evaluation.
   function automatic int mod_ref(input logic [W-1:0] v);
      int r = 0;
      for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % 107;
      return r;
   endfunction

   // Monitor and reference model; inputs are stable at the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         sending = (exp_q.size() != 0);
         chk("ld_ready", W'(bus.ld_ready), W'(!sending));
         chk("dg_valid", W'(bus.dg_valid), W'(sending));
         chk("busy",     W'(bus.busy),     W'(sending));
         if (sending) begin
            e = exp_q[0];
            chk("dg_data", W'(bus.dg_data), W'(e.data));
            chk("dg_idx",  W'(bus.dg_idx),  W'(e.idx));
            chk("dg_last", W'(bus.dg_last), W'(e.last));
            if (bus.dg_ready) begin
               void'(exp_q.pop_front());
               acc = (acc << D) | W'(bus.dg_data);
               res = (res + int'(bus.dg_data) * xk[bus.dg_idx]) % 107;
               if (e.last) begin
                  op = op_q.pop_front();
                  chk("operand", acc, op);
                  chk("residue", W'(res), W'(mod_ref(op)));
                  $display("operand done: %0h residue %0d", op, res);
               end
            end
         end else begin
            chk("dg_last_idle", W'(bus.dg_last), W'(0));
            if (bus.ld_valid) begin
               for (int k = N - 1; k >= 0; k--) begin
                  e.idx  = 6'(k);
                  e.data = D'(bus.ld_data >> (D * k));
                  e.last = (k == 0);
                  exp_q.push_back(e);
               end
               op_q.push_back(bus.ld_data);
               acc = '0;
               res = 0;
            end
         end
      end
   end

   task automatic step(input logic v, input logic r, input logic [W-1:0] d);
      @(posedge clk);
      #1;
      bus.ld_valid = v;
      bus.dg_ready = r;
      bus.ld_data  = d;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         step(1'b0, 1'b1, rnd_op());
         n++;
      end
      chk("drain_timeout", W'(exp_q.size() != 0), W'(0));
   endtask

   initial begin
      int cnt;
      int x;
      logic [W-1:0] d;
      x = 1;
      for (int k = 0; k < 64; k++) begin
         xk[k] = x;
         x = (x * 64) % 107;
      end
      acc = '0;
      res = 0;
      bus.ld_valid = 1'b0;
      bus.dg_ready = 1'b0;
      bus.ld_data  = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ld_ready", W'(bus.ld_ready), W'(1));
      chk("rst_dg_valid", W'(bus.dg_valid), W'(0));
      chk("rst_busy",     W'(bus.busy),     W'(0));
      chk("rst_dg_last",  W'(bus.dg_last),  W'(0));
      chk("rst_dg_idx",   W'(bus.dg_idx),   W'(0));
      chk("rst_dg_data",  W'(bus.dg_data),  W'(0));
      #2 rst_n = 1'b1;

      // Operand of value one.
      d = W'(1);
      step(1'b1, 1'b1, d);
      step(1'b0, 1'b1, '0);
      wait_idle(200);

      // All ones: busy must last exactly N cycles.
      step(1'b1, 1'b1, {W{1'b1}});
      cnt = 0;
      for (int i = 0; i < N + 10; i++) begin
         step(1'b0, 1'b1, '0);
         if (bus.busy) cnt++;
      end
      chk("busy_cycles", W'(cnt), W'(N));
      wait_idle(200);

      // Stall with the first digit presented.
      d = rnd_op();
      d[W-1 -: D] = D'(42);
      step(1'b1, 1'b0, d);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, '0);
         chk("stall_data", W'(bus.dg_data), W'(42));
         chk("stall_idx",  W'(bus.dg_idx),  W'(N - 1));
      end
      step(1'b0, 1'b1, '0);
      wait_idle(200);

      // Back-to-back operands with ld_valid held high.
      cnt = 0;
      for (int i = 0; i < 4 * (N + 1); i++) begin
         step(1'b1, 1'b1, rnd_op());
         if (bus.ld_ready) cnt++;
      end
      chk("ld_ready_pulses", W'(cnt), W'(4));
      step(1'b0, 1'b1, '0);
      wait_idle(200);

      // Reset while digit 20 is on the bus.
      step(1'b1, 1'b1, rnd_op());
      cnt = 0;
      while (!(exp_q.size() != 0 && exp_q[0].idx == 6'd20) && cnt < 200) begin
         step(1'b0, 1'b1, '0);
         cnt++;
      end
      chk("reach_idx20", W'(bus.dg_idx), W'(20));
      #2 rst_n = 1'b0;
      #1;
      chk("async_dg_valid", W'(bus.dg_valid), W'(0));
      chk("async_ld_ready", W'(bus.ld_ready), W'(1));
      chk("async_busy",     W'(bus.busy),     W'(0));
      exp_q.delete();
      op_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, rnd_op());
      step(1'b0, 1'b1, '0);
      chk("restart_idx", W'(bus.dg_idx), W'(N - 1));
      wait_idle(200);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), rnd_op());
      step(1'b0, 1'b1, '0);
      wait_idle(400);
      chk("ops_outstanding", W'(op_q.size()), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mod107_digit_serializer.md
MOD107_DIGIT_SERIALIZER -- requirements
Module: mod107_digit_serializer

Interface
REQ-001 SHALL have parameter W, default 300: operand width in bits.
REQ-002 SHALL have parameter D, default 6: digit width in bits; W SHALL be a multiple of D.
REQ-003 SHALL have derived constant N = W/D, 50 at defaults: digits per operand.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port ld_valid  input  1  operand offered.
REQ-007 SHALL have port ld_ready  output  1  serializer can accept an operand.
REQ-008 SHALL have port ld_data  input  W  binary operand; digit k = ld_data[D*k+D-1 : D*k].
REQ-009 SHALL have port dg_valid  output  1  digit presented to the mod-107 digit-LUT stage.
REQ-010 SHALL have port dg_ready  input  1  LUT stage accepts the digit.
REQ-011 SHALL have port dg_data  output  D  current digit; bit 0 drives the LUT x0 input.
REQ-012 SHALL have port dg_idx  output  6  digit index k (N-1 down to 0), selects the X_k LUT.
REQ-013 SHALL have port dg_last  output  1  high with the digit whose index is 0.
REQ-014 SHALL have port busy  output  1  high whenever an operand is held (state SEND).

Function
REQ-015 SHALL implement two states: IDLE and SEND.
REQ-016 In IDLE: ld_ready=1, dg_valid=0, busy=0.
REQ-017 Load handshake = ld_valid & ld_ready on a rising edge; SHALL capture ld_data into a W-bit shift register, set dg_idx=N-1, and enter SEND.
REQ-018 Latency: the first digit (k=N-1) SHALL be valid on the cycle immediately after the load edge.
REQ-019 In SEND: ld_ready=0, dg_valid=1, busy=1; ld_valid SHALL be ignored, with no overlap or queuing of operands.
REQ-020 dg_data SHALL be the top D bits of the shift register, i.e. digits go out MSB-first.
REQ-021 Digit transfer = dg_valid & dg_ready; on transfer with dg_idx>0, the register SHALL shift left by D bits, zero-filled, and dg_idx SHALL decrement by 1.
REQ-022 While dg_valid=1 and dg_ready=0, dg_data, dg_idx and dg_last SHALL hold stable.
REQ-023 Throughput SHALL be one digit per cycle when dg_ready is held high, so an operand takes N cycles in SEND.
REQ-024 dg_last SHALL equal (state==SEND && dg_idx==0).
REQ-025 On transfer with dg_idx==0, SHALL return to IDLE; ld_ready=1 on the next cycle.
REQ-026 An operand may load on the cycle ld_ready returns; back-to-back operands therefore cost N+1 cycles each.
REQ-027 dg_idx SHALL never wrap below 0 and never exceed N-1.
REQ-028 All outputs SHALL be registered or decoded only from state registers, with no combinational path from ld_valid or dg_ready to any output.

Reset
REQ-029 rst_n low SHALL asynchronously force: state=IDLE, shift register=0, dg_idx=0, dg_valid=0, dg_last=0, busy=0.
REQ-030 ld_ready SHALL read 1 during and after reset.
REQ-031 Reset in mid-SEND SHALL discard the operand; no further digits are issued after rst_n deasserts.
REQ-032 Operation SHALL resume with the first rising edge after rst_n deasserts.

Verification
REQ-033 Load ld_data = 300'h1 with dg_ready=1 -> 50 digits: idx 49..1 carry data 0, idx 0 carries data 1 with dg_last=1; ld_ready=1 on the next cycle.
REQ-034 Load all-ones with dg_ready=1 -> dg_data=6'h3F for 50 consecutive cycles, dg_last only on the 50th, busy high for exactly 50 cycles.
REQ-035 Load ld_data[299:294]=6'h2A, then hold dg_ready=0 for 5 cycles -> dg_data=6'h2A and dg_idx=49 stable for all 5 cycles; the digit advances only after dg_ready=1.
REQ-036 Assert ld_valid continuously with a new operand each load -> each operand is emitted complete and in order, ld_ready pulses once per 51 cycles, and no digit from operand B appears before dg_last of operand A.
REQ-037 Pull rst_n low at dg_idx=20 -> dg_valid=0 and ld_ready=1 asynchronously; after release, a fresh load restarts at idx 49.
REQ-038 Randomized dg_ready with a scoreboard -> concatenation of accepted digits equals ld_data, and the residue computed by the X_k LUT chain equals ld_data mod 107.
